// File: rtl/sccb_target.sv
// SCCB/I2C target that decodes oversampled SCL/SDA into register-file strobes.
// Optional SCCB_TARGET_GLITCH_FILTER_EN inserts a 3-sample majority filter per line.
module sccb_target #(
  parameter logic [7:0] DEVICE_ADDR    = 8'h78,
  parameter int         SUB_ADDR_WIDTH = 16,
  parameter int         SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rest,
  input  logic                      scl_in,
  input  logic                      sda_in,
  output logic                      sda_oe,
  output logic [SUB_ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]                reg_wdata,
  output logic                      reg_we,
  output logic                      reg_re,
  input  logic [7:0]                reg_rdata,
  output logic                      busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_ADDR_H, S_ADDR_H_ACK, S_ADDR_L, S_ADDR_L_ACK,
    S_WDATA, S_WDATA_ACK, S_RFETCH, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  localparam bit SUB16 = (SUB_ADDR_WIDTH == 16);

  state_t                    r_state, w_next;
  logic [SYNC_STAGES-1:0]    r_scl_sync, r_sda_sync;
  logic                      w_scl, w_sda;
  logic                      r_scl_d, r_sda_d;
  logic                      w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [2:0]                r_bit_cnt;
  logic [7:0]                r_shift, r_addr_hi, r_wdata;
  logic [7:0]                w_byte;
  logic [15:0]               w_addr16;
  logic                      w_last, w_match;
  logic                      r_rw, r_sda_oe, r_we, r_re;
  logic [SUB_ADDR_WIDTH-1:0] r_addr;

  // Idle bus is high, so synchronizers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef SCCB_TARGET_GLITCH_FILTER_EN
  logic [2:0] r_scl_h, r_sda_h;

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_scl_h <= '1;
      r_sda_h <= '1;
    end else begin
      r_scl_h <= {r_scl_h[1:0], r_scl_sync[SYNC_STAGES-1]};
      r_sda_h <= {r_sda_h[1:0], r_sda_sync[SYNC_STAGES-1]};
    end
  end

  assign w_scl = (r_scl_h[0] & r_scl_h[1]) | (r_scl_h[0] & r_scl_h[2]) | (r_scl_h[1] & r_scl_h[2]);
  assign w_sda = (r_sda_h[0] & r_sda_h[1]) | (r_sda_h[0] & r_sda_h[2]) | (r_sda_h[1] & r_sda_h[2]);
`else
  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = r_sda_d & ~w_sda & w_scl & r_scl_d;
  assign w_stop     = ~r_sda_d & w_sda & w_scl & r_scl_d;

  assign w_byte   = {r_shift[6:0], w_sda};
  assign w_addr16 = {r_addr_hi, w_byte};
  assign w_last   = (r_bit_cnt == 3'd7);
  assign w_match  = (w_byte[7:1] == DEVICE_ADDR[7:1]);

  always_ff @(posedge clk or posedge rest) begin
    if (rest) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    if (w_stop) begin
      w_next = S_IDLE;
    end else if (w_start) begin
      w_next = S_DEV;
    end else begin
      case (r_state)
        S_DEV:        if (w_scl_rise && w_last) w_next = w_match ? S_DEV_ACK : S_IGNORE;
        S_DEV_ACK:    if (w_scl_rise) w_next = r_rw ? S_RFETCH : (SUB16 ? S_ADDR_H : S_ADDR_L);
        S_ADDR_H:     if (w_scl_rise && w_last) w_next = S_ADDR_H_ACK;
        S_ADDR_H_ACK: if (w_scl_rise) w_next = S_ADDR_L;
        S_ADDR_L:     if (w_scl_rise && w_last) w_next = S_ADDR_L_ACK;
        S_ADDR_L_ACK: if (w_scl_rise) w_next = S_WDATA;
        S_WDATA:      if (w_scl_rise && w_last) w_next = S_WDATA_ACK;
        S_WDATA_ACK:  if (w_scl_rise) w_next = S_WDATA;
        S_RFETCH:     if (!r_re) w_next = S_RDATA;
        S_RDATA:      if (w_scl_rise && w_last) w_next = S_RDATA_ACK;
        S_RDATA_ACK:  if (w_scl_rise) w_next = w_sda ? S_IGNORE : S_RFETCH;
        default:      w_next = r_state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_addr_hi <= '0;
      r_wdata   <= '0;
      r_rw      <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_we <= 1'b0;
      r_re <= 1'b0;
      if (r_we) r_addr <= r_addr + SUB_ADDR_WIDTH'(1);
      if (w_start || w_stop) begin
        r_bit_cnt <= '0;
        r_sda_oe  <= 1'b0;
      end else begin
        if (r_state == S_RFETCH && !r_re) r_shift <= reg_rdata;
        if (w_scl_rise) begin
          case (r_state)
            S_DEV: begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last) r_rw <= w_sda;
            end
            S_ADDR_H: begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last) r_addr_hi <= w_byte;
            end
            S_ADDR_L: begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last) r_addr <= w_addr16[SUB_ADDR_WIDTH-1:0];
            end
            S_WDATA: begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last) begin
                r_wdata <= w_byte;
                r_we    <= 1'b1;
              end
            end
            S_RDATA:   r_bit_cnt <= r_bit_cnt + 3'd1;
            S_DEV_ACK: if (r_rw) r_re <= 1'b1;
            S_RDATA_ACK: begin
              if (!w_sda) begin
                r_addr <= r_addr + SUB_ADDR_WIDTH'(1);
                r_re   <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        if (w_scl_fall) begin
          case (r_state)
            S_DEV_ACK, S_ADDR_H_ACK, S_ADDR_L_ACK, S_WDATA_ACK: r_sda_oe <= 1'b1;
            S_RDATA: begin
              r_sda_oe <= ~r_shift[7];
              r_shift  <= {r_shift[6:0], 1'b0};
            end
            default: r_sda_oe <= 1'b0;
          endcase
        end
      end
    end
  end

  always_comb begin
    sda_oe    = r_sda_oe;
    reg_addr  = r_addr;
    reg_wdata = r_wdata;
    reg_we    = r_we;
    reg_re    = r_re;
    busy      = (r_state != S_IDLE) && (r_state != S_DEV) && (r_state != S_IGNORE);
  end

endmodule

// File: doc/sccb_target.md
Name: sccb_target

Overview:
- SCCB target (slave) responder for the SCCB/I2C-style bus.
- Serves a master such as the camera-config controller, and stands in for the OV5640 in simulation and loopback.
- Oversamples the SCL/SDA lines on the system clock, decodes the bus phases, and exposes writes and reads as single-cycle strobes on a register-file interface.
- Drives SDA open-drain only: it pulls SDA low or releases it.

Parameters:
- DEVICE_ADDR, 8'h78 — 8-bit write ID. Bit 0 is ignored on compare; the read ID is DEVICE_ADDR|1.
- SUB_ADDR_WIDTH, 16 — must be 8 or 16. When 8, the high sub-address byte phase is skipped.
- SYNC_STAGES, 2 — synchronizer depth for scl_in and sda_in; must be at least 2.

Ports:
- clk  input  1  system clock; must be at least 8x the SCL frequency.
- rest  input  1  asynchronous reset, active-high.
- scl_in  input  1  bus SCL, sampled.
- sda_in  input  1  bus SDA, sampled.
- sda_oe  output  1  1 = pull SDA low; 0 = release (external pull-up).
- reg_addr  output  SUB_ADDR_WIDTH  current register address.
- reg_wdata  output  8  write data, valid while reg_we is high.
- reg_we  output  1  one-clk write strobe.
- reg_re  output  1  one-clk read request.
- reg_rdata  input  8  read data, valid the clk after reg_re.
- busy  output  1  high from an address-matched START until STOP or release.

Behaviour:
- Reset: sda_oe, reg_we, reg_re and busy are 0; reg_addr and reg_wdata are 0; FSM is IDLE. Reset mid-transfer releases SDA asynchronously.
- Line conditioning: both lines pass through SYNC_STAGES flops, then single-flop edge detect.
  - START: sda fall while scl is high.
  - STOP: sda rise while scl is high.
  - sda is sampled on the detected scl rise; sda_oe changes only on the detected scl fall.
- FSM states: IDLE, DEV, DEV_ACK, ADDR_H, ADDR_H_ACK, ADDR_L, ADDR_L_ACK, WDATA, WDATA_ACK, RFETCH, RDATA, RDATA_ACK, IGNORE.
- Priority rules:
  - START in any state goes to DEV (repeated start) with the bit counter cleared.
  - STOP in any state goes to IDLE with sda_oe=0 and busy=0.
- DEV: shift 8 bits MSB first.
  - If byte[7:1] matches DEVICE_ADDR[7:1], go to DEV_ACK and pull sda_oe=1 for the 9th SCL period, released on the following scl fall.
  - On mismatch, go to IGNORE. IGNORE never asserts sda_oe and exits only on START or STOP.
- Write ID (bit 0 = 0) sequence:
  - ADDR_H (16-bit only), ACK, ADDR_L, ACK. reg_addr is loaded with the received sub-address.
  - Then WDATA, WDATA_ACK, repeating.
  - After the 8th data bit: reg_wdata = byte, reg_we pulses for 1 clk with the current reg_addr, then reg_addr increments (wraps at 2^SUB_ADDR_WIDTH-1 to 0).
  - Each data byte is acknowledged with sda_oe=1.
- Address-only write (2-phase SCCB): STOP after ADDR_L_ACK leaves reg_addr retained for a later read.
- Read ID (bit 0 = 1) sequence:
  - After DEV_ACK, enter RFETCH: reg_re pulses for 1 clk on the DEV_ACK scl rise, and reg_rdata is latched into the shift register the next clk.
  - RDATA: on each scl fall, sda_oe = ~shift[7]; shift left. The first bit is driven on the scl fall that ends DEV_ACK.
  - After 8 bits, release SDA and sample the master on the 9th scl rise.
    - Low (ACK): reg_addr++, re-enter RFETCH, next byte.
    - High (NA): go to IGNORE and wait for STOP.
- Partial byte followed by STOP or START: discarded, no strobe issued.
- reg_we and reg_re are never high in the same clk.

Optional Feature:
- Macro SCCB_TARGET_GLITCH_FILTER_EN.
- Defined: after synchronization, each line passes a 3-sample majority filter, adding 2 clk latency. Single-clk pulses on scl_in/sda_in are rejected and never cause a START, STOP or bit event.
- Undefined: synchronizer output feeds edge detect directly, and any glitch of at least 1 clk is treated as an edge.

Test Plan:
- Write phases 0x78, 0x5A, 0x98, 0x23, STOP -> sda_oe low in each of 4 ACK slots; a single reg_we with reg_addr=0x5A98, reg_wdata=0x23; busy low after STOP.
- Write 0x78, 0x30, 0x08, STOP; then START 0x79 with reg_rdata=0x42; master NA -> reg_re pulses once at addr 0x3008; bus carries 0x42; SDA released; no reg_we.
- Burst write 0x78, 0x43, 0x00, 0x11, 0x22, 0x33 -> reg_we at 0x4300/0x11, 0x4301/0x22, 0x4302/0x33; reg_addr ends at 0x4303.
- ID 0xA4 write then data -> sda_oe stays 0 throughout; no reg_we/reg_re; busy stays 0.
- Assert rest during the 5th bit of an RDATA byte at 0x00 -> sda_oe=0 within the reset assertion (asynchronous); the following full write transaction completes normally.
- STOP after 4 bits of ADDR_L, or (with SCCB_TARGET_GLITCH_FILTER_EN) a 1-clk SDA dip while SCL is high -> FSM IDLE with no strobe, or no spurious START/STOP respectively.
